pool_map_packer: RTL and testbench

//  Sink stage after the max-pool output: collects the 8-bit pooled feature-map stream
//  (valid_in/pix_in, no backpressure) and packs 4 pixels per 32-bit word.

---
 rtl/pool_map_packer_if.sv | 23 ++
 rtl/pool_map_packer.sv | 150 +++++++++++++++
 tb/tb_pool_map_packer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pool_map_packer_if.sv
// pool_map_packer_if
//  Stream-side bundle of the pooled-map packer.
//  It groups the incoming pixel stream with the outgoing valid/ready word port.
//   valid_in / pix_in : pooled pixel stream, raster order, no backpressure
//   m_ready           : downstream accepts the head word
//   m_valid / m_data  : head word of the word FIFO
//   m_last            : the head word is the last word of a frame
//  Modports:
//   master : the environment side. It drives pixels and m_ready.
//   slave  : the packer side.
interface pool_map_packer_if;
  logic        valid_in;
  logic [7:0]  pix_in;
  logic        m_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;

  modport master (output valid_in, pix_in, m_ready,
                  input  m_valid, m_data, m_last);
  modport slave  (input  valid_in, pix_in, m_ready,
                  output m_valid, m_data, m_last);
endinterface

// File: rtl/pool_map_packer.sv
// pool_map_packer
//  Sink stage after the max-pool output.
//  Packing:
//   - Four 8-bit pooled pixels go into each 32-bit word. The first pixel sits in [7:0].
//   - Row ends do not break a word. Only the last pixel of a frame closes a partial
//     word, and the unwritten lanes of that word are zero.
//  Word FIFO:
//   - Completed words are pushed into a show-ahead FIFO that feeds a valid/ready port.
//   - When the FIFO is full and nothing pops on the same edge, the word is dropped
//     and overflow is set.
//  Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   clear       : synchronous frame restart; flushes every piece of state
//   bus         : pixel stream in, word stream out (pool_map_packer_if.slave)
//   frame_done  : 1-cycle pulse, the cycle after an m_last word is accepted
//   overflow    : sticky; a word was dropped because the FIFO was full
//   fill_level  : number of words held in the FIFO
module pool_map_packer #(
  parameter int IMG_W      = 109,
  parameter int IMG_H      = 109,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  pool_map_packer_if.slave            bus,
  output logic                        frame_done,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fill_level
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  // Raster position and partial-word state
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [1:0]    r_lane;
  logic [23:0]   r_pack;   // lanes 0..2; lane 3 always completes a word

  // Word FIFO: {last, data}
  logic [32:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [LW-1:0] r_count;
  logic          r_overflow;
  logic          r_frame_done;

  logic          w_frame_end;
  logic          w_complete;
  logic          w_pop;
  logic          w_full;
  logic          w_write;
  logic          w_drop;
  logic [31:0]   w_word;
  logic [32:0]   w_head;

  // The word as it would look with the current pixel merged into its lane.
  // Lanes that have not been written yet stay zero, because r_pack is cleared
  // every time a word completes.
  always_comb begin
    // NOTE: assign a full default before the partial overwrite so no latch is inferred.
    w_word = {8'h00, r_pack};
    w_word[{r_lane, 3'b000} +: 8] = bus.pix_in;
  end

  assign w_frame_end = (r_col == CW'(IMG_W - 1)) && (r_row == RW'(IMG_H - 1));
  assign w_complete  = bus.valid_in && ((r_lane == 2'd3) || w_frame_end);
  assign w_pop       = (r_count != '0) && bus.m_ready;
  assign w_full      = (r_count == LW'(FIFO_DEPTH));
  // A pop on the same edge frees the slot, so a full FIFO still accepts the word.
  assign w_write     = w_complete && (!w_full || w_pop);
  assign w_drop      = w_complete && w_full && !w_pop;
  assign w_head      = r_mem[r_rd_ptr];

  // Packer and raster counters. A dropped word still advances these counters,
  // so frame alignment is kept.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_lane <= '0;
      r_pack <= '0;
    end else if (clear) begin
      r_col  <= '0;
      r_row  <= '0;
      r_lane <= '0;
      r_pack <= '0;
    end else if (bus.valid_in) begin
      if (w_complete) begin
        r_lane <= '0;
        r_pack <= '0;
      end else begin
        r_lane <= r_lane + 2'd1;
        r_pack <= w_word[23:0];
      end
      if (r_col == CW'(IMG_W - 1)) begin
        r_col <= '0;
        r_row <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // FIFO pointers, occupancy and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (clear) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
      r_frame_done <= w_pop && w_head[32];
    end
  end

  // Word storage. Only the occupancy counter says which entries are live, so the
  // array itself needs no reset.
  // NOTE: the memory is deliberately left unreset; the outputs are gated by m_valid, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (w_write && !clear) r_mem[r_wr_ptr] <= {w_frame_end, w_word};
  end

  assign bus.m_valid = (r_count != '0);
  assign bus.m_data  = bus.m_valid ? w_head[31:0] : 32'h0;
  assign bus.m_last  = bus.m_valid && w_head[32];
  assign frame_done  = r_frame_done;
  assign overflow    = r_overflow;
  assign fill_level  = r_count;

endmodule

// File: tb/tb_pool_map_packer.sv
// tb_pool_map_packer
//  Self-checking bench for pool_map_packer. The packer is built with a 3x3 map and
//  an 8-word FIFO.
//  Scoreboard model, sampled on the falling edge:
//   - Expected words are pushed to a queue when the stimulus completes a word.
//   - Each head word is compared against the DUT output, and popped when the DUT
//     hands the word over.
//  Directed checks: constant expected words, levels and flags at the points of
//  interest.
module tb_pool_map_packer;

  localparam int W = 3;
  localparam int H = 3;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic       frame_done;
  logic       overflow;
  logic [3:0] fill_level;

  pool_map_packer_if bus ();

  pool_map_packer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bus        (bus),
    .frame_done (frame_done),
    .overflow   (overflow),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard model state
  logic [32:0] q[$];
  int          m_lane, m_col, m_row;
  logic [31:0] m_word;
  logic        m_ovf, m_fd;
  // Words and last flags actually handed over by the DUT
  logic [31:0] got_words[$];
  logic        got_last[$];
  int          fd_count = 0;

  task automatic model_reset();
    q.delete();
    m_lane = 0; m_col = 0; m_row = 0; m_word = '0;
    m_ovf = 1'b0; m_fd = 1'b0;
  endtask

  always @(negedge clk) begin
    bit          pop, fend, fd_next;
    logic [32:0] push_val;
    bit          push;
    if (!rst_n) model_reset();
    check("m_valid",    bus.m_valid, q.size() != 0);
    check("fill_level", fill_level,  q.size());
    check("overflow",   overflow,    m_ovf);
    check("frame_done", frame_done,  m_fd);
    if (q.size() != 0) begin
      check("m_data", bus.m_data, q[0][31:0]);
      check("m_last", bus.m_last, q[0][32]);
    end
    if (frame_done) fd_count++;
    if (bus.m_valid && bus.m_ready) begin
      got_words.push_back(bus.m_data);
      got_last.push_back(bus.m_last);
    end
    if (rst_n) begin
      if (clear) begin
        model_reset();
      end else begin
        pop     = bus.m_ready && (q.size() != 0);
        fd_next = pop && q[0][32];
        push    = 1'b0;
        if (bus.valid_in) begin
          fend = (m_col == W - 1) && (m_row == H - 1);
          m_word[m_lane*8 +: 8] = bus.pix_in;
          if (m_lane == 3 || fend) begin
            push = 1'b1;
            push_val = {fend, m_word};
            m_word = '0;
            m_lane = 0;
          end else begin
            m_lane++;
          end
          if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
          end else begin
            m_col++;
          end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
          if (q.size() < D) q.push_back(push_val);
          else m_ovf = 1'b1;
        end
        m_fd = fd_next;
      end
    end
  end

  task automatic drive_pix(input logic [7:0] p, input bit rdy);
    @(posedge clk); #1;
    bus.valid_in = 1'b1;
    bus.pix_in   = p;
    bus.m_ready  = rdy;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      bus.pix_in   = 8'($urandom);   // must be ignored while valid_in is low
      bus.m_ready  = rdy;
    end
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear        = 1'b1;
    bus.valid_in = 1'b1;             // this pixel must be dropped
    bus.pix_in   = 8'h77;
    @(posedge clk); #1;
    clear        = 1'b0;
    bus.valid_in = 1'b0;
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.pix_in   = 8'h00;
    bus.m_ready  = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset asserted mid-stream with a word waiting in the FIFO
    for (int i = 0; i < 5; i++) drive_pix(8'hE0 + 8'(i), 1'b0);
    idle(1'b0, 2);
    check("pre_reset_fill", fill_level, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_m_valid",    bus.m_valid, 0);
    check("rst_fill",       fill_level,  0);
    check("rst_overflow",   overflow,    0);
    check("rst_frame_done", frame_done,  0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Pixels 01..09 with m_ready high: two full words, then the padded last word
    got_words.delete(); got_last.delete(); fd_count = 0;
    for (int i = 1; i <= 9; i++) drive_pix(8'(i), 1'b1);
    // Next frame starts with no gap: 0A..0D form a fresh word
    for (int i = 10; i <= 13; i++) drive_pix(8'(i), 1'b1);
    idle(1'b1, 4);
    check("n_words_a", got_words.size(), 4);
    check("word0",     got_words[0], 32'h04030201);
    check("word1",     got_words[1], 32'h08070605);
    check("word2",     got_words[2], 32'h00000009);
    check("word3",     got_words[3], 32'h0D0C0B0A);
    check("last0",     got_last[0],  0);
    check("last1",     got_last[1],  0);
    check("last2",     got_last[2],  1);
    check("last3",     got_last[3],  0);
    check("fd_count",  fd_count,     1);

    // Overflow: 36 pixels with m_ready low give 12 words; only the first 8 are kept
    do_clear();
    for (int i = 1; i <= 36; i++) drive_pix(8'(i), 1'b0);
    idle(1'b0, 2);
    check("full_fill",     fill_level, 8);
    check("full_overflow", overflow,   1);
    got_words.delete(); got_last.delete();
    idle(1'b1, 14);
    check("drain_count", got_words.size(), 8);
    check("drain_first", got_words[0], 32'h04030201);
    check("drain_last",  got_words[7], 32'h1A191817);
    check("ovf_sticky",  overflow,     1);

    // Clear after 2 pixels while overflow is set; the frame restarts at 0,0
    idle(1'b1, 1);
    drive_pix(8'h55, 1'b1);
    drive_pix(8'h66, 1'b1);
    do_clear();
    check("clr_fill",     fill_level, 0);
    check("clr_overflow", overflow,   0);
    got_words.delete(); got_last.delete();
    drive_pix(8'hAA, 1'b1); drive_pix(8'hBB, 1'b1);
    drive_pix(8'hCC, 1'b1); drive_pix(8'hDD, 1'b1);
    for (int i = 1; i <= 5; i++) drive_pix(8'(i), 1'b1);
    idle(1'b1, 4);
    check("clr_n_words", got_words.size(), 3);
    check("clr_word0",   got_words[0], 32'hDDCCBBAA);
    check("clr_word1",   got_words[1], 32'h04030201);
    check("clr_word2",   got_words[2], 32'h00000005);
    check("clr_last2",   got_last[2],  1);

    // Full FIFO with a pop on the same edge as a push
    do_clear();
    for (int i = 1; i <= 26; i++) drive_pix(8'(i), 1'b0);
    idle(1'b0, 1);
    check("pp_fill_before", fill_level, 8);
    got_words.delete(); got_last.delete();
    drive_pix(8'd27, 1'b1);
    idle(1'b0, 1);
    check("pp_fill_after", fill_level, 8);
    check("pp_overflow",   overflow,   0);
    idle(1'b1, 12);
    check("pp_n_words", got_words.size(), 9);
    check("pp_word8",   got_words[8], 32'h0000001B);
    check("pp_last8",   got_last[8],  1);
    check("pp_ovf_end", overflow,     0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
